// File: rtl/trace_pkg.sv
// Shared definitions for the trace capture unit: FSM state encodings,
// entry-width derivation and the bit offsets of each entry field.
// Build option: TRACE_TIMESTAMP_EN adds a timestamp field in the entry MSBs.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_POST    = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

`ifdef TRACE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    // Total stored entry width: {[ts,] pc, instr}
    function automatic int entry_width(input int ts_w, input int pc_w, input int instr_w);
        return (TS_EN ? ts_w : 0) + pc_w + instr_w;
    endfunction

    // Field LSB positions inside an entry
    function automatic int instr_lsb();
        return 0;
    endfunction

    function automatic int pc_lsb(input int instr_w);
        return instr_w;
    endfunction

    function automatic int ts_lsb(input int pc_w, input int instr_w);
        return pc_w + instr_w;
    endfunction

endpackage

// File: rtl/trace_buf.sv
// Circular trace storage: DEPTH x ENTRY_W with write/read pointers, occupancy
// count, optional overwrite of the oldest entry when full, and a registered
// read port producing a one-cycle valid pulse per pop.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module trace_buf #(
    parameter  int DEPTH   = 16,
    parameter  int ENTRY_W = 32,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr_i,
    input  logic               wr_en_i,
    input  logic               wrap_i,
    input  logic [ENTRY_W-1:0] wr_data_i,
    input  logic               rd_en_i,
    output logic [ENTRY_W-1:0] rd_data_o,
    output logic               rd_valid_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               overflow_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               overflow_q;
    logic [ENTRY_W-1:0] rd_data_q;
    logic               rd_valid_q;
    logic               full, empty, do_wr, do_ovw, do_rd;

    // Access qualification: a full buffer only accepts writes in wrap mode
    always_comb begin
        full    = (count_q == CNT_W'(DEPTH));
        empty   = (count_q == '0);
        do_wr   = wr_en_i && (!full || wrap_i);
        do_ovw  = wr_en_i && full && wrap_i;
        do_rd   = rd_en_i && !empty;
    end

    // Storage array; contents are don't-care after reset so it carries none
    always_ff @(posedge clk) begin
        if (do_wr && !clr_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers, count, sticky overflow and registered read port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (clr_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= do_rd;
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_ovw) begin
                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                overflow_q <= 1'b1;
            end else if (do_rd) begin
                rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
                rd_data_q <= mem_q[rd_ptr_q];
            end
            if (do_wr && !do_ovw && !do_rd) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_rd && !do_wr) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign count_o    = count_q;
    assign full_o     = full;
    assign empty_o    = empty;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/trace_capture_unit.sv
// Instruction trace and halt-trigger unit: records retired {pc, instr} pairs,
// watches for a trigger PC, captures POST_TRIG further entries, then halts
// and lets the debug host pop the trace oldest-first.
// Build option: TRACE_TIMESTAMP_EN stores a free-running cycle stamp per entry.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | after reset; retires ignored, waiting for arm
// CAPTURE | recording every retire, comparing pc against trig_pc
// POST    | trigger seen; recording the remaining post-trigger entries
// DONE    | capture finished; halt_req high, rd_en pops the trace
module trace_capture_unit
    import trace_pkg::*;
#(
    parameter  int PC_W      = 16,
    parameter  int INSTR_W   = 16,
    parameter  int DEPTH     = 16,
    parameter  int POST_TRIG = 4,
    parameter  int TS_W      = 16,
    localparam int ENTRY_W   = entry_width(TS_W, PC_W, INSTR_W),
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arm,
    input  logic               wrap_mode,
    input  logic [PC_W-1:0]    trig_pc,
    input  logic               retire,
    input  logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               rd_en,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_valid,
    output logic               halt_req,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   count,
    output logic               triggered,
    output logic               overflow
);

    // Wide enough to hold POST_TRIG, and at least one bit when POST_TRIG is 0
    localparam int PCNT_W = $clog2(POST_TRIG + 2);

    state_e              state_q, state_d;
    logic [PCNT_W-1:0]   post_q, post_d;
    logic                trig_q, trig_d;
    logic                buf_clr, buf_wr, buf_rd, buf_full, buf_empty;
    logic                hit, stop_full;
    logic [ENTRY_W-1:0]  wr_data;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    // Entries carry the counter value as it stands after their write edge,
    // so the first retire one cycle after arm is stamped 1
    always_comb begin
        ts_d = arm ? '0 : ts_q + TS_W'(1);
    end

    // Free-running cycle counter, cleared by arm
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign wr_data = {ts_d, pc, instr};
`else
    assign wr_data = {pc, instr};
`endif

    // The write that brings the buffer to DEPTH ends capture in stop mode
    assign hit       = (pc == trig_pc);
    assign stop_full = !wrap_mode && ((count >= CNT_W'(DEPTH - 1)) || buf_full);

    // Next-state, post counter, trigger flag and buffer controls
    always_comb begin
        state_d = state_q;
        post_d  = post_q;
        trig_d  = trig_q;
        buf_clr = 1'b0;
        buf_wr  = 1'b0;
        buf_rd  = 1'b0;
        if (arm) begin
            buf_clr = 1'b1;
            trig_d  = 1'b0;
            post_d  = '0;
            state_d = ST_CAPTURE;
        end else begin
            case (state_q)
                ST_CAPTURE: begin
                    if (retire) begin
                        buf_wr = 1'b1;
                        if (hit) begin
                            trig_d = 1'b1;
                        end
                        if (stop_full) begin
                            state_d = ST_DONE;
                        end else if (hit) begin
                            if (POST_TRIG == 0) begin
                                state_d = ST_DONE;
                            end else begin
                                post_d  = PCNT_W'(POST_TRIG);
                                state_d = ST_POST;
                            end
                        end
                    end
                end
                ST_POST: begin
                    if (retire) begin
                        buf_wr = 1'b1;
                        post_d = post_q - PCNT_W'(1);
                        if (stop_full || post_q == PCNT_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    buf_rd = rd_en;
                end
                default: begin
                end
            endcase
        end
    end

    // FSM state, post counter and sticky trigger registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            post_q  <= '0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            post_q  <= post_d;
            trig_q  <= trig_d;
        end
    end

    trace_buf #(
        .DEPTH  (DEPTH),
        .ENTRY_W(ENTRY_W)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (buf_clr),
        .wr_en_i   (buf_wr),
        .wrap_i    (wrap_mode),
        .wr_data_i (wr_data),
        .rd_en_i   (buf_rd),
        .rd_data_o (rd_data),
        .rd_valid_o(rd_valid),
        .count_o   (count),
        .full_o    (buf_full),
        .empty_o   (buf_empty),
        .overflow_o(overflow)
    );

    assign halt_req  = (state_q == ST_DONE);
    assign state     = state_q;
    assign triggered = trig_q;

    logic unused_ok;
    assign unused_ok = buf_empty;

endmodule

// File: tb/tb_trace_capture_unit.sv
module tb_trace_capture_unit;
    localparam int PC_W = 16, INSTR_W = 16, DEPTH = 16, POST_TRIG = 4, TS_W = 16;
`ifdef TRACE_TIMESTAMP_EN
    localparam int EW = TS_W + PC_W + INSTR_W;
`else
    localparam int EW = PC_W + INSTR_W;
`endif
    localparam int CW = 5;

    logic          clk = 1'b0, reset = 1'b0, arm = 1'b0, wrap_mode = 1'b0;
    logic          retire = 1'b0, rd_en = 1'b0;
    logic [15:0]   trig_pc = '0, pc = '0, instr = '0;
    logic [EW-1:0] rd_data;
    logic          rd_valid, halt_req, triggered, overflow;
    logic [1:0]    state;
    logic [CW-1:0] count;

    int            vectors = 0, miscompares = 0;
    logic [31:0]   exp_q [$];
    logic [31:0]   exp_e;

    trace_capture_unit #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .TS_W(TS_W)
    ) dut (
        .clk(clk), .reset(reset), .arm(arm), .wrap_mode(wrap_mode), .trig_pc(trig_pc),
        .retire(retire), .pc(pc), .instr(instr), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .halt_req(halt_req), .state(state), .count(count),
        .triggered(triggered), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Stimulus helpers: entered and left just after a falling edge
    task automatic do_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic ret(input logic [15:0] p);
        retire = 1'b1;
        pc     = p;
        instr  = p + 16'h100;
        @(negedge clk);
        retire = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            arm = i[0]; retire = ~i[0]; rd_en = 1'b1; pc = 16'(i);
            @(negedge clk);
        end
        arm = 1'b0; retire = 1'b0; rd_en = 1'b0;
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL rst_state got=%0d want=0", state); end
        vectors++; if (count !== '0) begin miscompares++; $display("FAIL rst_count got=%0d want=0", count); end
        vectors++; if (halt_req !== 1'b0) begin miscompares++; $display("FAIL rst_halt got=%b want=0", halt_req); end
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rd_valid got=%b want=0", rd_valid); end
        vectors++; if (triggered !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL rst_flags got=%b%b want=00", triggered, overflow); end
        vectors++; if (rd_data !== '0) begin miscompares++; $display("FAIL rst_rd_data got=%h want=0", rd_data); end
        reset = 1'b1;
        @(negedge clk);
        ret(16'd3);
        vectors++; if (count !== '0 || state !== 2'd0) begin miscompares++; $display("FAIL idle_ignores_retire count=%0d state=%0d want 0/0", count, state); end
    endtask

    task automatic test_trigger_post();
        trig_pc = 16'd10; wrap_mode = 1'b0; exp_q.delete();
        do_arm();
        for (int p = 0; p < 15; p++) begin
            if (p == 14) begin
                vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL tp_before_last state=%0d want=2", state); end
            end
            ret(16'(p));
            exp_q.push_back({16'(p), 16'(p) + 16'h100});
        end
        vectors++; if (state !== 2'd3 || halt_req !== 1'b1) begin miscompares++; $display("FAIL tp_done state=%0d halt=%b want 3/1", state, halt_req); end
        vectors++; if (count !== CW'(15) || triggered !== 1'b1) begin miscompares++; $display("FAIL tp_count_trig count=%0d trig=%b want 15/1", count, triggered); end
        rd_en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 14) rd_en = 1'b0;
            exp_e = exp_q.pop_front();
            vectors++; if (rd_valid !== 1'b1 || rd_data[31:0] !== exp_e) begin miscompares++; $display("FAIL tp_read%0d got=%h v=%b want=%h", i, rd_data[31:0], rd_valid, exp_e); end
        end
        @(negedge clk);
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL tp_valid_pulse got=%b want=0", rd_valid); end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        vectors++; if (rd_valid !== 1'b0 || count !== '0 || state !== 2'd3) begin miscompares++; $display("FAIL tp_empty_pop v=%b count=%0d state=%0d want 0/0/3", rd_valid, count, state); end
    endtask

    task automatic test_stop_full();
        trig_pc = 16'd100; wrap_mode = 1'b0; exp_q.delete();
        do_arm();
        vectors++; if (halt_req !== 1'b0 || state !== 2'd1) begin miscompares++; $display("FAIL sf_rearm halt=%b state=%0d want 0/1", halt_req, state); end
        for (int p = 0; p < 18; p++) begin
            if (p == 15) begin
                vectors++; if (state !== 2'd1 || count !== CW'(15)) begin miscompares++; $display("FAIL sf_pre_full state=%0d count=%0d want 1/15", state, count); end
            end
            if (p == 16) begin
                vectors++; if (state !== 2'd3 || count !== CW'(16)) begin miscompares++; $display("FAIL sf_full state=%0d count=%0d want 3/16", state, count); end
            end
            ret(16'(p));
            if (p < 16) exp_q.push_back({16'(p), 16'(p) + 16'h100});
        end
        vectors++; if (count !== CW'(16) || triggered !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL sf_flags count=%0d trig=%b ovf=%b want 16/0/0", count, triggered, overflow); end
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 15) rd_en = 1'b0;
            exp_e = exp_q.pop_front();
            vectors++; if (rd_valid !== 1'b1 || rd_data[31:0] !== exp_e) begin miscompares++; $display("FAIL sf_read%0d got=%h v=%b want=%h", i, rd_data[31:0], rd_valid, exp_e); end
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        trig_pc = 16'd19; wrap_mode = 1'b1; exp_q.delete();
        do_arm();
        for (int p = 0; p < 24; p++) begin
            if (p == 20) begin
                vectors++; if (state !== 2'd2 || triggered !== 1'b1 || overflow !== 1'b1) begin miscompares++; $display("FAIL wr_post state=%0d trig=%b ovf=%b want 2/1/1", state, triggered, overflow); end
            end
            ret(16'(p));
            exp_q.push_back({16'(p), 16'(p) + 16'h100});
            if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
        end
        vectors++; if (state !== 2'd3 || overflow !== 1'b1 || count !== CW'(16)) begin miscompares++; $display("FAIL wr_done state=%0d ovf=%b count=%0d want 3/1/16", state, overflow, count); end
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 15) rd_en = 1'b0;
            exp_e = exp_q.pop_front();
            vectors++; if (rd_valid !== 1'b1 || rd_data[31:0] !== exp_e) begin miscompares++; $display("FAIL wr_read%0d got=%h v=%b want=%h", i, rd_data[31:0], rd_valid, exp_e); end
        end
        @(negedge clk);
        wrap_mode = 1'b0;
    endtask

    task automatic test_back_to_back_rearm();
        trig_pc = 16'd30; exp_q.delete();
        do_arm();
        ret(16'd0);
        ret(16'd1);
        arm = 1'b1; retire = 1'b1; pc = 16'd5; instr = 16'h105;
        @(negedge clk);
        arm = 1'b0; retire = 1'b0;
        vectors++; if (count !== '0 || state !== 2'd1 || triggered !== 1'b0) begin miscompares++; $display("FAIL col_clear count=%0d state=%0d trig=%b want 0/1/0", count, state, triggered); end
        for (int p = 30; p < 35; p++) begin
            ret(16'(p));
            exp_q.push_back({16'(p), 16'(p) + 16'h100});
        end
        vectors++; if (state !== 2'd3 || count !== CW'(5) || halt_req !== 1'b1) begin miscompares++; $display("FAIL col_done state=%0d count=%0d halt=%b want 3/5/1", state, count, halt_req); end
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) rd_en = 1'b0;
            exp_e = exp_q.pop_front();
            vectors++; if (rd_valid !== 1'b1 || rd_data[31:0] !== exp_e) begin miscompares++; $display("FAIL col_read%0d got=%h v=%b want=%h", i, rd_data[31:0], rd_valid, exp_e); end
        end
        @(negedge clk);
        do_arm();
        vectors++; if (halt_req !== 1'b0 || state !== 2'd1) begin miscompares++; $display("FAIL col_rearm halt=%b state=%0d want 0/1", halt_req, state); end
    endtask

    task automatic test_reset_mid_post();
        trig_pc = 16'd40; wrap_mode = 1'b0;
        do_arm();
        ret(16'd40);
        ret(16'd41);
        ret(16'd42);
        vectors++; if (state !== 2'd2 || count !== CW'(3)) begin miscompares++; $display("FAIL rp_in_post state=%0d count=%0d want 2/3", state, count); end
        reset = 1'b0;
        #1;
        vectors++; if (state !== 2'd0 || count !== '0) begin miscompares++; $display("FAIL rp_async state=%0d count=%0d want 0/0", state, count); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (halt_req !== 1'b0 || triggered !== 1'b0 || state !== 2'd0) begin miscompares++; $display("FAIL rp_idle halt=%b trig=%b state=%0d want 0/0/0", halt_req, triggered, state); end
        trig_pc = 16'd50;
        do_arm();
        for (int p = 50; p < 55; p++) ret(16'(p));
        vectors++; if (state !== 2'd3 || count !== CW'(5)) begin miscompares++; $display("FAIL rp_done state=%0d count=%0d want 3/5", state, count); end
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) rd_en = 1'b0;
            exp_e = {16'(50 + i), 16'(50 + i) + 16'h100};
            vectors++; if (rd_valid !== 1'b1 || rd_data[31:0] !== exp_e) begin miscompares++; $display("FAIL rp_read%0d got=%h want=%h", i, rd_data[31:0], exp_e); end
`ifdef TRACE_TIMESTAMP_EN
            vectors++; if (rd_data[EW-1:32] !== TS_W'(i + 1)) begin miscompares++; $display("FAIL rp_ts%0d got=%0d want=%0d", i, rd_data[EW-1:32], i + 1); end
`endif
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_trigger_post();
        test_stop_full();
        test_wrap();
        test_back_to_back_rearm();
        test_reset_mid_post();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trace_capture_unit.md
# trace_capture_unit

- Synthesizable instruction-trace and halt-trigger unit for the 16-bit processor.
- Records retired {pc, instruction} pairs into a circular buffer of parametrised depth and detects a programmable trigger PC.
- After the trigger, captures a configurable number of post-trigger instructions, then raises a halt request and lets a debug host read the trace out in order.
- Replaces ad-hoc "run until PC == N" testbench stopping with an on-chip mechanism.

## Interface
Parameters:
- PC_W, 16, program counter width
- INSTR_W, 16, instruction width
- DEPTH, 16, trace entries; power of two, ≥2
- POST_TRIG, 4, entries captured after the trigger entry (0 allowed)
- TS_W, 16, timestamp width (used only with TRACE_TIMESTAMP_EN)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- arm  in  1  single-cycle pulse; clears the buffer and starts capture
- wrap_mode  in  1  1 = circular overwrite when full; 0 = stop when full
- trig_pc  in  PC_W  trigger address
- retire  in  1  one instruction retired this cycle
- pc  in  PC_W  PC of the retiring instruction
- instr  in  INSTR_W  retiring instruction word
- rd_en  in  1  pop the oldest entry (honoured only in DONE)
- rd_data  out  ENTRY_W  popped entry {[ts,] pc, instr}, registered
- rd_valid  out  1  rd_data valid this cycle
- halt_req  out  1  high while in DONE
- state  out  2  IDLE=0, CAPTURE=1, POST=2, DONE=3
- count  out  $clog2(DEPTH)+1  entries held
- triggered  out  1  sticky; trigger PC seen since last arm
- overflow  out  1  sticky; an entry was overwritten (wrap mode)

## Operation
- Reset: state=IDLE; count, pointers, post counter, triggered, overflow, halt_req, rd_valid and rd_data all 0.
- IDLE: ignores retire. arm → CAPTURE; clears pointers, count, triggered and overflow.
- CAPTURE: each retire writes {pc, instr} at wr_ptr and increments wr_ptr, wrapping modulo DEPTH.
  - If pc == trig_pc: set triggered. POST_TRIG=0 → DONE; otherwise load post counter = POST_TRIG → POST.
- POST: each retire writes an entry and decrements the post counter; the write that takes it to 0 → DONE.
- Full buffer (count == DEPTH) with a retire:
  - wrap_mode=1: overwrite the oldest entry; rd_ptr advances; count stays DEPTH; overflow=1.
  - wrap_mode=0: the write that makes count reach DEPTH → DONE. Stop-on-full takes precedence over the trigger/POST path; triggered is still set if that entry matched.
- DONE: no writes; halt_req=1.
  - rd_en with count>0: rd_data = entry at rd_ptr, rd_valid=1; rd_ptr increments; count decrements.
  - rd_en with count=0: rd_valid=0; no state change.
- arm in any state clears and enters CAPTURE. arm wins over a same-cycle retire, which is not recorded.
- rd_en outside DONE is ignored.
- Reset mid-operation aborts immediately to IDLE; buffer contents become don't-care.
- wrap_mode is sampled per write; changing it mid-capture is legal.

## Timing
- Write latency: an entry is stored on the rising edge where retire=1. count, state and triggered update on that same edge and are visible the next cycle.
- halt_req rises in the cycle after the final entry's write edge and falls the cycle after arm.
- Read latency: 1 cycle. rd_en at edge N gives rd_data/rd_valid valid after edge N+1.
- rd_valid is a single-cycle pulse per accepted pop. Back-to-back rd_en gives one entry per cycle.
- Throughput: one retire per cycle, sustained.

## Configuration
- TRACE_TIMESTAMP_EN defined:
  - TS_W-bit free-running cycle counter; 0 on reset, cleared by arm, wraps modulo 2^TS_W.
  - Each entry stores the counter value at write time in its MSBs.
  - ENTRY_W = TS_W+PC_W+INSTR_W.
- Undefined: no counter; ENTRY_W = PC_W+INSTR_W; behaviour otherwise identical.

## Structure
- Package trace_pkg:
  - state encodings (IDLE/CAPTURE/POST/DONE)
  - ENTRY_W derivation
  - entry field offset constants
- Sub-module trace_buf: DEPTH×ENTRY_W storage with pointers, count, full/empty, overwrite-on-full, and registered read port.
- The top level holds the FSM, trigger compare, post counter and optional timestamp counter.

## Test plan
All scenarios use DEPTH=16 and POST_TRIG=4.
- Reset: hold reset=0, toggle inputs → state=0, count=0, halt_req=0, rd_valid=0, triggered=0, overflow=0.
- Trigger + post: arm, trig_pc=10, wrap_mode=0, retire pc 0..14 (instr = pc+0x100) → DONE after pc 14; count=15, triggered=1, halt_req=1; 15 rd_en pulses return pc 0..14 in order, then rd_en gives rd_valid=0.
- Stop-on-full: trig_pc=100, wrap_mode=0, retire pc 0..17 → DONE after pc 15; count=16, triggered=0, overflow=0; pcs 16, 17 not stored.
- Wrap: trig_pc=19, wrap_mode=1, retire pc 0..23 → DONE after pc 23; overflow=1, count=16; readout pc 8..23.
- Re-arm/collision: arm and retire (pc 5) in the same cycle during CAPTURE → count=0, pc 5 absent. Re-arm in DONE clears halt_req next cycle.
- Reset mid-POST: reset=0 for one cycle after two post entries → IDLE, count=0; with TRACE_TIMESTAMP_EN, first entry after the next arm has ts=1 when retire comes one cycle after arm.
